fft_mem_scheduler: RTL



---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_addr_gen.sv | 66 ++++++
 rtl/fft_mem_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT sample-RAM scheduler.
package fft_pkg;

  localparam int unsigned N_LOG2_DEF   = 10;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned BFLY_LAT_DEF = 16;
  // Tag address field width; must be at least the largest N_LOG2 instantiated.
  localparam int unsigned TAG_ADDR_W   = N_LOG2_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [TAG_ADDR_W-1:0] addr_a;
    logic [TAG_ADDR_W-1:0] addr_b;
  } tag_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Stage/butterfly counters and in-place radix-2 DIT address/twiddle generation.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = N_LOG2_DEF,
  localparam int unsigned STAGE_W = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              k_adv_i,
  input  logic              stage_adv_i,
  output logic [STAGE_W-1:0] stage_o,
  output logic [N_LOG2-1:0] addr_a_o,
  output logic [N_LOG2-1:0] addr_b_o,
  output logic [N_LOG2-2:0] tw_o,
  output logic              last_k_o,
  output logic              last_stage_o
);

  localparam int unsigned K_W = N_LOG2 - 1;

  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [N_LOG2-1:0]  k_ext, span, pos, base;
  logic [STAGE_W:0]   up_shift;

  // k wraps to zero after the last butterfly so the next stage starts clean.
  always_comb begin
    stage_d = stage_q;
    k_d     = k_q;
    if (clr_i) begin
      stage_d = '0;
      k_d     = '0;
    end else begin
      if (k_adv_i)     k_d     = k_q + K_W'(1);
      if (stage_adv_i) stage_d = stage_q + STAGE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
      k_q     <= '0;
    end else begin
      stage_q <= stage_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    k_ext        = N_LOG2'(k_q);
    span         = N_LOG2'(1) << stage_q;
    pos          = k_ext & (span - N_LOG2'(1));
    up_shift     = (STAGE_W+1)'(stage_q) + (STAGE_W+1)'(1);
    base         = (k_ext >> stage_q) << up_shift;
    addr_a_o     = base | pos;
    addr_b_o     = addr_a_o + span;
    tw_o         = K_W'(pos << (STAGE_W'(K_W) - stage_q));
    last_k_o     = &k_q;
    last_stage_o = (stage_q == STAGE_W'(N_LOG2 - 1));
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/fft_mem_scheduler.sv
// In-place radix-2 DIT FFT sequencer and host arbiter for a dual-port sample RAM.
// Optional build macro FFT_SCHED_STAGE_SCALE_EN adds a per-stage butterfly halving flag.
module fft_mem_scheduler
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2   = N_LOG2_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned BFLY_LAT = BFLY_LAT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [N_LOG2-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_gnt,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic [N_LOG2-1:0] o_ram_addr_a,
  output logic [N_LOG2-1:0] o_ram_addr_b,
  output logic              o_ram_we_a,
  output logic              o_ram_we_b,
  output logic [DATA_W-1:0] o_ram_wdata_a,
  output logic [DATA_W-1:0] o_ram_wdata_b,
  input  logic [DATA_W-1:0] i_ram_rdata_a,
  input  logic [DATA_W-1:0] i_ram_rdata_b,
`ifdef FFT_SCHED_STAGE_SCALE_EN
  input  logic [N_LOG2-1:0] i_scale_mask,
  output logic              o_bf_scale,
`endif
  output logic              o_bf_valid,
  output logic [DATA_W-1:0] o_bf_a,
  output logic [DATA_W-1:0] o_bf_b,
  output logic [N_LOG2-2:0] o_bf_tw_idx,
  input  logic [DATA_W-1:0] i_bf_x,
  input  logic [DATA_W-1:0] i_bf_y
);

  localparam int unsigned DEPTH   = BFLY_LAT + 1;
  localparam int unsigned STAGE_W = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;

  state_e             state_q, state_d;
  tag_t               tag_q [DEPTH];
  tag_t               tag_in, tag_out;
  logic               busy_q, done_q, bf_valid_q;
  logic [N_LOG2-2:0]  tw_q;
  logic [STAGE_W-1:0] stage;
  logic [N_LOG2-1:0]  gen_addr_a, gen_addr_b;
  logic [N_LOG2-2:0]  gen_tw;
  logic               last_k, last_stage;
  logic               wb_c, rd_c, pending_c, stage_adv_c, gen_clr_c, host_gnt_c;

  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .clr_i        (gen_clr_c),
    .k_adv_i      (rd_c),
    .stage_adv_i  (stage_adv_c),
    .stage_o      (stage),
    .addr_a_o     (gen_addr_a),
    .addr_b_o     (gen_addr_b),
    .tw_o         (gen_tw),
    .last_k_o     (last_k),
    .last_stage_o (last_stage)
  );

  assign tag_out   = tag_q[DEPTH-1];
  assign wb_c      = tag_out.valid;
  assign rd_c      = (state_q == ST_RUN) && !wb_c;
  assign gen_clr_c = (state_q == ST_IDLE);
  assign host_gnt_c = i_host_req && !i_rst && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Tags still in flight other than the one writing back this cycle.
  always_comb begin
    pending_c = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) pending_c = pending_c | tag_q[i].valid;
  end

  always_comb begin
    state_d     = state_q;
    stage_adv_c = 1'b0;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_RUN;
      ST_RUN:   if (rd_c && last_k) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // Leave on the cycle of the last write so the next read sees written data.
        if (!pending_c) begin
          if (last_stage) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_RUN;
            stage_adv_c = 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tag_in        = '0;
    tag_in.valid  = rd_c;
    tag_in.addr_a = TAG_ADDR_W'(gen_addr_a);
    tag_in.addr_b = TAG_ADDR_W'(gen_addr_b);
  end

  // RAM port mux: write-back beats butterfly read beats host.
  always_comb begin
    o_ram_addr_a  = '0;
    o_ram_addr_b  = '0;
    o_ram_we_a    = 1'b0;
    o_ram_we_b    = 1'b0;
    o_ram_wdata_a = '0;
    o_ram_wdata_b = '0;
    if (!i_rst) begin
      if (wb_c) begin
        o_ram_addr_a  = N_LOG2'(tag_out.addr_a);
        o_ram_addr_b  = N_LOG2'(tag_out.addr_b);
        o_ram_we_a    = 1'b1;
        o_ram_we_b    = 1'b1;
        o_ram_wdata_a = i_bf_x;
        o_ram_wdata_b = i_bf_y;
      end else if (rd_c) begin
        o_ram_addr_a = gen_addr_a;
        o_ram_addr_b = gen_addr_b;
      end else if (host_gnt_c) begin
        o_ram_addr_a  = i_host_addr;
        o_ram_we_a    = i_host_we;
        o_ram_wdata_a = i_host_wdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      tw_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
      bf_valid_q <= rd_c;
      if (rd_c) tw_q <= gen_tw;
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifdef FFT_SCHED_STAGE_SCALE_EN
  logic scale_q;
  always_ff @(posedge i_clk) begin
    if (i_rst)     scale_q <= 1'b0;
    else if (rd_c) scale_q <= i_scale_mask[stage];
  end
  assign o_bf_scale = scale_q;
`else
  logic unused_stage;
  assign unused_stage = ^stage;
`endif

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_bf_valid   = bf_valid_q;
  assign o_bf_tw_idx  = tw_q;
  assign o_bf_a       = i_ram_rdata_a;
  assign o_bf_b       = i_ram_rdata_b;
  assign o_host_gnt   = host_gnt_c;
  assign o_host_rdata = i_ram_rdata_a;

endmodule
